rs_erasure_decoder: RTL and testbench
=====================================

# rs_erasure_decoder

Rank-level RS(10,8) decoder over GF(2^8) that corrects up to two erased 8-bit symbols (chips) whose positions are flagged by a per-symbol DUE/erasure vector. It takes an 80-bit codeword (8 data symbols and 2 parity symbols) and returns 64 corrected data bits plus a 2-bit decode status. It sits behind the rank-level first-pass decoder, which supplies the erasure locations. Outputs are registered.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- codeword_in  in  80  symbol j = codeword_in[8j+7:8j], j=0..9; symbols 9..2 are data, symbols 1..0 are parity.
- DUE_information_in  in  10  bit j=1 marks symbol j as erased.
- decode_result_out  out  2  00 no error (NE), 01 corrected (CE), 10 uncorrectable (DUE), 11 never driven.
- data_out  out  64  corrected codeword[79:16].

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α=0x02. Symbol j has locator α^j.
- Syndromes: S0 = XOR of all c_j; S1 = XOR of c_j·α^j. The all-zero word is a codeword.
- Let n = popcount(DUE_information_in).
- n=0: if S0=S1=0, the result is NE. Otherwise the result is DUE (see Configuration). data_out is the raw data.
- n=1 at position j:
  - S0=S1=0 gives NE.
  - If S1 = S0·α^j and S0≠0, then e=S0, c_j ^= e, and the result is CE.
  - Any other syndrome gives DUE.
- n=2 at positions i>j:
  - e_i = (S1 ⊕ S0·α^j)·(α^i ⊕ α^j)^-1 and e_j = S0 ⊕ e_i.
  - XOR e_i into c_i and e_j into c_j.
  - Both errors zero gives NE; otherwise CE.
- n≥3: the result is DUE and data_out is the raw data.
- Corrections in parity symbols (j≤1) are applied but do not appear on data_out.
- On DUE, data_out always carries the uncorrected codeword[79:16].

## Timing
- Single stage. Inputs are sampled on rising clk; the decode is combinational; both outputs are registered.
- Latency is 1 cycle. Throughput is one codeword per cycle. There is no handshake and no valid signal.
- rst high at an edge sets decode_result_out=2'b00 and data_out=64'h0, overriding any input sampled at that edge. Decoding resumes on the first edge with rst low.
- Inputs must be stable around the sampling edge. There is no internal state besides the output registers.

## Configuration
- RS_SEC_EN defined: for n=0 with a nonzero syndrome, the block attempts single-symbol error correction.
  - If S0≠0 and S1·S0^-1 = α^j for some j in 0..9, then c_j ^= S0 and the result is CE.
  - Otherwise the result is DUE.
- RS_SEC_EN undefined: n=0 with a nonzero syndrome is always DUE.

## Structure
- Package rs_pkg holds:
  - the primitive polynomial constant 8'h1D;
  - the ALPHA_POW[0:9] locator table;
  - the decode-result encoding constants NE/CE/DUE;
  - a GF(2^8) inverse function (256-entry table or x^254).
- Sub-module gf256_mul: combinational 8×8 GF(2^8) multiplier, instantiated for syndrome, consistency and erasure-value products.

## Test plan
- Reset asserted → decode_result_out=00 and data_out=0. All-zero codeword with DUE=0 after release → 00, data 0, one cycle later.
- DUE=10'b10_0000_0000, codeword[79:72]=8'hA3, all else 0 → 01, data_out=64'h0.
- DUE=10'b01_0000_0000, codeword[71:64]=8'hA3, all else 0 → 01, data_out=0.
- DUE=10'b10_0100_0000, [79:72]=8'hA3, [55:48]=8'h5F, all else 0 → 01, data_out=0. Repeat with DUE=10'b10_0000_0010, [79:72]=8'hA3, [15:8]=8'h79 → 01, data_out=0.
- DUE=10'b10_0000_0000, codeword[47:40]=8'h01, all else 0 (error outside the erasure) → 10, data_out equal to the raw codeword[79:16].
- DUE=10'b11_1000_0000 with any nonzero data → 10, raw data. Without RS_SEC_EN, DUE=0 with [79:72]=8'hA3 → 10. With RS_SEC_EN, the same stimulus → 01, data 0.

Source files
------------

// File: rtl/rs_pkg.sv
// GF(2^8) constants and helpers shared by the RS(10,8) erasure decoder.
package rs_pkg;

  localparam logic [7:0] PRIM_POLY = 8'h1D;

  localparam logic [7:0] ALPHA_POW [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A
  };

  localparam logic [1:0] RES_NE  = 2'b00;
  localparam logic [1:0] RES_CE  = 2'b01;
  localparam logic [1:0] RES_DUE = 2'b10;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? PRIM_POLY : 8'h00);
    end
    return acc;
  endfunction

  // x^-1 = x^254; gf_inv(0) yields 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_erasure_decoder_gf256_mul.sv
// Combinational GF(2^8) multiplier, field polynomial 0x11D.
module gf256_mul
  import rs_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] sh;

  always_comb begin
    p_o = 8'h00;
    sh  = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) p_o = p_o ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? PRIM_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/rs_erasure_decoder.sv
// RS(10,8) GF(2^8) decoder correcting up to two flagged erasures; registered outputs.
// Optional macro RS_SEC_EN adds single-symbol error correction when nothing is flagged.
module rs_erasure_decoder
  import rs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] codeword_in,
  input  logic [9:0]  DUE_information_in,
  output logic [1:0]  decode_result_out,
  output logic [63:0] data_out
);

  logic [7:0]  sym    [10];
  logic [7:0]  sprod  [10];
  logic [7:0]  s0, s1;
  logic [3:0]  n_erased;
  logic [3:0]  pos_lo, pos_hi;
  logic [7:0]  alpha_lo, alpha_hi;
  logic [7:0]  s0_alo, e_hi, e_lo;
  logic [79:0] err_vec;
  logic [79:0] corrected;
  logic [1:0]  result_d, result_q;
  logic [63:0] data_d, data_q;

  for (genvar j = 0; j < 10; j++) begin : g_synd
    assign sym[j] = codeword_in[8*j +: 8];
    gf256_mul u_synd (.a_i(sym[j]), .b_i(ALPHA_POW[j]), .p_o(sprod[j]));
  end

  always_comb begin
    s0 = 8'h00;
    s1 = 8'h00;
    for (int j = 0; j < 10; j++) begin
      s0 = s0 ^ sym[j];
      s1 = s1 ^ sprod[j];
    end
  end

  always_comb begin
    n_erased = 4'd0;
    pos_lo   = 4'd0;
    pos_hi   = 4'd0;
    for (int k = 0; k < 10; k++) begin
      n_erased = n_erased + {3'b000, DUE_information_in[k]};
      if (DUE_information_in[k]) pos_hi = k[3:0];
    end
    for (int k = 9; k >= 0; k--) begin
      if (DUE_information_in[k]) pos_lo = k[3:0];
    end
  end

  assign alpha_lo = ALPHA_POW[pos_lo];
  assign alpha_hi = ALPHA_POW[pos_hi];

  // S0*a^lo serves both the single-erasure consistency test and the two-erasure solve.
  gf256_mul u_cons (.a_i(s0), .b_i(alpha_lo), .p_o(s0_alo));
  gf256_mul u_eval (.a_i(s1 ^ s0_alo), .b_i(gf_inv(alpha_hi ^ alpha_lo)), .p_o(e_hi));
  assign e_lo = s0 ^ e_hi;

`ifdef RS_SEC_EN
  logic [7:0] sec_loc;
  logic       sec_hit;
  logic [3:0] sec_pos;

  gf256_mul u_sec (.a_i(s1), .b_i(gf_inv(s0)), .p_o(sec_loc));

  always_comb begin
    sec_hit = 1'b0;
    sec_pos = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (sec_loc == ALPHA_POW[k]) begin
        sec_hit = 1'b1;
        sec_pos = k[3:0];
      end
    end
  end
`endif

  always_comb begin
    result_d = RES_NE;
    err_vec  = '0;
    case (n_erased)
      4'd0: begin
        if ((s0 | s1) != 8'h00) begin
`ifdef RS_SEC_EN
          if (s0 != 8'h00 && sec_hit) begin
            result_d                = RES_CE;
            err_vec[8*sec_pos +: 8] = s0;
          end else begin
            result_d = RES_DUE;
          end
`else
          result_d = RES_DUE;
`endif
        end
      end
      4'd1: begin
        if ((s0 | s1) == 8'h00) begin
          result_d = RES_NE;
        end else if (s0 != 8'h00 && s1 == s0_alo) begin
          result_d               = RES_CE;
          err_vec[8*pos_lo +: 8] = s0;
        end else begin
          result_d = RES_DUE;
        end
      end
      4'd2: begin
        err_vec[8*pos_hi +: 8] = e_hi;
        err_vec[8*pos_lo +: 8] = e_lo;
        result_d = ((e_hi | e_lo) == 8'h00) ? RES_NE : RES_CE;
      end
      default: result_d = RES_DUE;
    endcase
  end

  assign corrected = codeword_in ^ err_vec;
  assign data_d    = (result_d == RES_DUE) ? codeword_in[79:16] : corrected[79:16];

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= RES_NE;
      data_q   <= 64'h0;
    end else begin
      result_q <= result_d;
      data_q   <= data_d;
    end
  end

  assign decode_result_out = result_q;
  assign data_out          = data_q;

endmodule

// File: tb/tb_rs_erasure_decoder.sv
// Directed bench for rs_erasure_decoder with hand-computed expectations.
module tb_rs_erasure_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] codeword_in;
  logic [9:0]  DUE_information_in;
  logic [1:0]  decode_result_out;
  logic [63:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_erasure_decoder dut (
    .clk               (clk),
    .rst               (rst),
    .codeword_in       (codeword_in),
    .DUE_information_in(DUE_information_in),
    .decode_result_out (decode_result_out),
    .data_out          (data_out)
  );

  task automatic check(input string tag, input logic [1:0] exp_res, input logic [63:0] exp_data);
    checks++;
    assert (decode_result_out === exp_res) else begin
      errors++;
      $error("FAIL %s result: observed %b expected %b", tag, decode_result_out, exp_res);
    end
    checks++;
    assert (data_out === exp_data) else begin
      errors++;
      $error("FAIL %s data: observed %h expected %h", tag, data_out, exp_data);
    end
  endtask

  task automatic apply(input logic [79:0] cw, input logic [9:0] due);
    @(negedge clk);
    codeword_in        = cw;
    DUE_information_in = due;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    codeword_in        = {8'hA3, 72'h0};
    DUE_information_in = 10'h000;
    @(posedge clk);
    #1;
    check("reset", 2'b00, 64'h0);
    @(posedge clk);
    #1;
    check("reset_hold", 2'b00, 64'h0);

    @(negedge clk);
    rst = 1'b0;
    apply(80'h0, 10'h000);
    check("zero_word", 2'b00, 64'h0);

    // Output must not change before the next sampling edge.
    @(negedge clk);
    codeword_in        = {8'hA3, 72'h0};
    DUE_information_in = 10'b10_0000_0000;
    #3;
    check("latency_hold", 2'b00, 64'h0);
    @(posedge clk);
    #1;
    check("erase_s9", 2'b01, 64'h0);

    apply({8'h00, 8'hA3, 64'h0}, 10'b01_0000_0000);
    check("erase_s8", 2'b01, 64'h0);

    apply({72'h0, 8'h77, 16'h0}, 10'b00_0000_0100);
    check("erase_s2", 2'b01, 64'h0);

    apply({8'hA3, 16'h0, 8'h5F, 48'h0}, 10'b10_0100_0000);
    check("erase_s9_s6", 2'b01, 64'h0);

    apply({8'hA3, 56'h0, 8'h79, 8'h00}, 10'b10_0000_0010);
    check("erase_s9_s1", 2'b01, 64'h0);

    // Only parity erased: parity fix is internal, data passes untouched.
    apply({8'hA3, 72'h0}, 10'b00_0000_0011);
    check("erase_parity", 2'b01, 64'hA300_0000_0000_0000);

    apply(80'h0, 10'b00_0001_0000);
    check("erase_clean1", 2'b00, 64'h0);

    apply(80'h0, 10'b10_0000_0001);
    check("erase_clean2", 2'b00, 64'h0);

    apply({32'h0, 8'h01, 40'h0}, 10'b10_0000_0000);
    check("err_outside", 2'b10, 64'h0000_0000_0100_0000);

    apply({8'h12, 8'h34, 8'h56, 56'h0}, 10'b11_1000_0000);
    check("three_erased", 2'b10, 64'h1234_5600_0000_0000);

    apply({8'hA3, 72'h0}, 10'h000);
`ifdef RS_SEC_EN
    check("no_flag_err", 2'b01, 64'h0);
`else
    check("no_flag_err", 2'b10, 64'hA300_0000_0000_0000);
`endif

    @(negedge clk);
    rst = 1'b1;
    codeword_in        = {8'hA3, 72'h0};
    DUE_information_in = 10'b10_0000_0000;
    @(posedge clk);
    #1;
    check("reset_mid", 2'b00, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("resume", 2'b01, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
